// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port data memory.
// Fixed priority to the CPU port with a bounded starvation count for the debug port.
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT_M1   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_L = 4'(STARVE_MAX);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic              r_owner;
    logic [3:0]        r_starve;
    logic [3:0]        r_wcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant;
    logic              w_pick_d;

    // D only wins a tie once the CPU has been granted STARVE_MAX times in a row.
    always_comb begin
        w_grant  = c_req | d_req;
        w_pick_d = d_req && (!c_req || (r_starve == STARVE_L));
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
            S_WAIT:  if (r_wcnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_wen  = (r_state == S_ISSUE) && r_we;
        mem_ren  = (r_state == S_ISSUE) && !r_we;
        c_ack    = (r_state == S_RESP) && !r_owner;
        d_ack    = (r_state == S_RESP) && r_owner;
        busy     = (r_state != S_IDLE);
        owner    = r_owner;
        mem_addr = r_addr;
        mem_din  = r_wdata;
        c_rdata  = r_c_rdata;
        d_rdata  = r_d_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_owner   <= 1'b0;
            r_starve  <= 4'd0;
            r_wcnt    <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_pick_d;
                        r_we    <= w_pick_d ? d_we : c_we;
                        r_addr  <= w_pick_d ? d_addr : c_addr;
                        r_wdata <= w_pick_d ? d_wdata : c_wdata;
                    end
                    if (!d_req || w_pick_d) begin
                        r_starve <= 4'd0;
                    end else if (r_starve != STARVE_L) begin
                        r_starve <= r_starve + 4'd1;
                    end
                end
                S_ISSUE: r_wcnt <= LAT_M1;
                S_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        if (r_owner) r_d_rdata <= mem_dout;
                        else         r_c_rdata <= mem_dout;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
